// File: rtl/dm_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage normally owns the port, and an external
// master gets a slot on an idle CPU cycle or after STARVE_MAX consecutive CPU grants.
module dm_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_type,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [2:0]  ext_type,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [2:0]  dm_type,
    input  logic [31:0] dm_dout
);

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_CPU     = 1'b0,
        ST_EXT_ACK = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  starve_r;
    logic [3:0]  starve_nxt_s;
    logic        ext_ack_r;
    logic [31:0] ext_rdata_r;
    logic        ext_gnt_s;
    logic        cpu_gnt_s;
    logic        starve_full_s;

    assign starve_full_s = (starve_r == STARVE_MAX_C);

    // Grant decision; reset low suppresses every grant so no write or stall leaks out.
    always_comb begin
        ext_gnt_s = 1'b0;
        cpu_gnt_s = 1'b0;
        if (rstn) begin
            ext_gnt_s = (state_r == ST_CPU) & ext_req & (~cpu_req | starve_full_s);
            cpu_gnt_s = cpu_req & ~ext_gnt_s;
        end else begin
            ext_gnt_s = 1'b0;
            cpu_gnt_s = 1'b0;
        end
    end

    // Memory port mux; CPU fields are the idle default.
    always_comb begin
        dm_addr = cpu_addr;
        dm_din  = cpu_wdata;
        dm_type = cpu_type;
        if (ext_gnt_s) begin
            dm_addr = ext_addr;
            dm_din  = ext_wdata;
            dm_type = ext_type;
        end else begin
            dm_addr = cpu_addr;
            dm_din  = cpu_wdata;
            dm_type = cpu_type;
        end
    end

    assign dm_we     = (ext_gnt_s & ext_we) | (cpu_gnt_s & cpu_we);
    assign cpu_stall = cpu_req & ext_gnt_s;
    assign cpu_rdata = dm_dout;
    assign ext_ack   = ext_ack_r;
    assign ext_rdata = ext_rdata_r;

    // Next-state logic; the ack cycle never grants the external port again.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CPU: begin
                if (ext_gnt_s) begin
                    state_nxt_s = ST_EXT_ACK;
                end else begin
                    state_nxt_s = ST_CPU;
                end
            end
            ST_EXT_ACK: state_nxt_s = ST_CPU;
            default:    state_nxt_s = ST_CPU;
        endcase
    end

    // Starvation counter next value: restarts whenever the master is served or withdraws.
    always_comb begin
        starve_nxt_s = starve_r;
        if (ext_gnt_s || !ext_req) begin
            starve_nxt_s = 4'd0;
        end else if (cpu_gnt_s && (starve_r < STARVE_MAX_C)) begin
            starve_nxt_s = starve_r + 4'd1;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    // State, counter and external response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_CPU;
            starve_r    <= 4'd0;
            ext_ack_r   <= 1'b0;
            ext_rdata_r <= 32'd0;
        end else begin
            state_r   <= state_nxt_s;
            starve_r  <= starve_nxt_s;
            ext_ack_r <= ext_gnt_s;
            if (ext_gnt_s) begin
                ext_rdata_r <= dm_dout;
            end else begin
                ext_rdata_r <= ext_rdata_r;
            end
        end
    end

    dm_arbiter_checker u_checker (
        .clk       (clk),
        .rstn      (rstn),
        .cpu_req   (cpu_req),
        .ext_req   (ext_req),
        .cpu_stall (cpu_stall),
        .ext_ack   (ext_ack_r),
        .dm_we     (dm_we)
    );

endmodule

// Protocol properties of the arbiter outputs, kept apart from the datapath.
module dm_arbiter_checker (
    input logic clk,
    input logic rstn,
    input logic cpu_req,
    input logic ext_req,
    input logic cpu_stall,
    input logic ext_ack,
    input logic dm_we
);

    a_stall_single: assert property (@(posedge clk) disable iff (!rstn) cpu_stall |=> !cpu_stall);
    a_ack_single:   assert property (@(posedge clk) disable iff (!rstn) ext_ack |=> !ext_ack);
    a_we_granted:   assert property (@(posedge clk) disable iff (!rstn) dm_we |-> (cpu_req | ext_req));

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance at STARVE_MAX=4 on a small memory model,
// a second at STARVE_MAX=0 for the strict-priority case.
module tb_dm_arbiter;

    logic        clk;
    logic        rstn;

    logic        cpu_req, cpu_we, ext_req, ext_we;
    logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
    logic [2:0]  cpu_type, ext_type;
    logic [31:0] cpu_rdata, ext_rdata, dm_addr, dm_din, dm_dout;
    logic        cpu_stall, ext_ack, dm_we;
    logic [2:0]  dm_type;

    logic        z_cpu_req, z_ext_req;
    logic [31:0] z_cpu_rdata, z_ext_rdata, z_dm_addr, z_dm_din, z_dm_dout;
    logic        z_cpu_stall, z_ext_ack, z_dm_we;
    logic [2:0]  z_dm_type;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;

    dm_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_type(cpu_type), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_type(ext_type), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type), .dm_dout(dm_dout)
    );

    dm_arbiter #(.STARVE_MAX(0)) dut0 (
        .clk(clk), .rstn(rstn),
        .cpu_req(z_cpu_req), .cpu_we(1'b0), .cpu_addr(32'h0000_0040), .cpu_wdata(32'd0),
        .cpu_type(3'd0), .cpu_rdata(z_cpu_rdata), .cpu_stall(z_cpu_stall),
        .ext_req(z_ext_req), .ext_we(1'b0), .ext_addr(32'h0000_0080), .ext_wdata(32'd0),
        .ext_type(3'd0), .ext_ack(z_ext_ack), .ext_rdata(z_ext_rdata),
        .dm_we(z_dm_we), .dm_addr(z_dm_addr), .dm_din(z_dm_din), .dm_type(z_dm_type),
        .dm_dout(z_dm_dout)
    );

    // Combinational-read, clocked-write memory behind the main instance.
    assign dm_dout   = mem[dm_addr[7:2]];
    assign z_dm_dout = z_dm_addr ^ 32'hA5A5_A5A5;

    always @(posedge clk) begin
        if (dm_we) mem[dm_addr[7:2]] <= dm_din;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_stall;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234_5678; cpu_type = 3'd2;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20; ext_wdata = 32'd0; ext_type = 3'd2;
        z_cpu_req = 1'b0; z_ext_req = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;

        // 1: reset forces outputs even with requests pending
        step(); step();
        check_eq("rst_dm_we", 32'(dm_we), 32'd0);
        check_eq("rst_stall", 32'(cpu_stall), 32'd0);
        check_eq("rst_ack", 32'(ext_ack), 32'd0);
        check_eq("rst_rdata", ext_rdata, 32'd0);
        ext_req = 1'b0;
        rstn = 1'b1;
        #1;
        check_eq("cpu_st_we", 32'(dm_we), 32'd1);
        check_eq("cpu_st_addr", dm_addr, 32'h10);
        check_eq("cpu_st_din", dm_din, 32'h1234_5678);
        step();
        cpu_we = 1'b0;
        #1;
        check_eq("cpu_ld_we", 32'(dm_we), 32'd0);
        check_eq("cpu_ld_data", cpu_rdata, 32'h1234_5678);

        // 4: strict priority instance, held ext_req gives alternate grant/ack cycles
        z_cpu_req = 1'b1; z_ext_req = 1'b1;
        prev_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check_eq($sformatf("sp_stall_%0d", i), 32'(z_cpu_stall), 32'((i % 2) == 0));
            check_eq($sformatf("sp_ack_%0d", i), 32'(z_ext_ack), 32'((i % 2) == 1));
            check_eq($sformatf("sp_back2back_%0d", i), 32'(prev_stall & z_cpu_stall), 32'd0);
            prev_stall = z_cpu_stall;
            step();
        end
        z_ext_req = 1'b0;
        #1;
        check_eq("sp_idle_stall", 32'(z_cpu_stall), 32'd0);

        // 2: external write with idle CPU
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20; ext_wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("ext_wr_we", 32'(dm_we), 32'd1);
        check_eq("ext_wr_addr", dm_addr, 32'h20);
        check_eq("ext_wr_ack_n", 32'(ext_ack), 32'd0);
        step();
        #1;
        check_eq("ext_wr_ack_n1", 32'(ext_ack), 32'd1);
        check_eq("ext_wr_nogrant", 32'(dm_we), 32'd0);
        step();
        ext_req = 1'b0;
        #1;
        check_eq("ext_wr_ack_n2", 32'(ext_ack), 32'd0);
        step();
        ext_req = 1'b1; ext_we = 1'b0;
        #1;
        check_eq("ext_rd_we", 32'(dm_we), 32'd0);
        step();
        check_eq("ext_rd_ack", 32'(ext_ack), 32'd1);
        check_eq("ext_rd_data", ext_rdata, 32'hDEAD_BEEF);
        ext_req = 1'b0;
        step();

        // 3: starvation with STARVE_MAX=4
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h20;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("sv_stall_%0d", c), 32'(cpu_stall), 32'd0);
            check_eq($sformatf("sv_addr_%0d", c), dm_addr, 32'h10);
            step();
        end
        #1;
        check_eq("sv_cnt_full", 32'(dut.starve_r), 32'd4);
        check_eq("sv_stall_4", 32'(cpu_stall), 32'd1);
        check_eq("sv_addr_4", dm_addr, 32'h20);
        step();
        #1;
        check_eq("sv_ack_5", 32'(ext_ack), 32'd1);
        check_eq("sv_rdata_5", ext_rdata, 32'hDEAD_BEEF);
        check_eq("sv_cnt_clr", 32'(dut.starve_r), 32'd0);
        check_eq("sv_stall_5", 32'(cpu_stall), 32'd0);
        check_eq("sv_addr_5", dm_addr, 32'h10);
        check_eq("sv_cpu_data_5", cpu_rdata, 32'h1234_5678);
        step();
        ext_req = 1'b0;
        step();

        // 5: a withdrawn request restarts the count
        ext_req = 1'b1;
        step(); step();
        ext_req = 1'b0;
        step();
        ext_req = 1'b1;
        #1;
        check_eq("cc_cnt_restart", 32'(dut.starve_r), 32'd0);
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq($sformatf("cc_stall_%0d", c), 32'(cpu_stall), 32'd0);
            step();
        end
        #1;
        check_eq("cc_grant", 32'(cpu_stall), 32'd1);
        step();
        check_eq("cc_ack", 32'(ext_ack), 32'd1);
        ext_req = 1'b0;
        step();

        // 6: reset during the ack cycle drops the ack at once
        cpu_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h24; ext_wdata = 32'h0000_0005;
        #1;
        check_eq("mr_we", 32'(dm_we), 32'd1);
        step();
        check_eq("mr_ack_pre", 32'(ext_ack), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("mr_ack_async", 32'(ext_ack), 32'd0);
        check_eq("mr_rdata", ext_rdata, 32'd0);
        ext_req = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        check_eq("mr_state", 32'(dut.state_r), 32'd0);
        check_eq("mr_ack_post", 32'(ext_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

- Shares the single data-memory port between two requesters:
  - the pipeline CPU's MEM-stage load/store path;
  - an external master (program loader or debug port).
- Sits between `SCPU`'s data-bus outputs and `dm`.
- Each granted access completes in one cycle, because `dm` reads combinationally and writes on the clock edge.
- The CPU has priority. If the external master has waited for `STARVE_MAX` consecutive CPU grants, it is granted anyway, and the CPU is stalled for that cycle.

## Interface

Parameters:
- STARVE_MAX, default 4: maximum number of consecutive CPU grants while `ext_req` is pending. Legal range 0..15. A value of 0 gives the external port strict priority.

Ports:
- clk  in  1  CPU clock; all state changes on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU has a load or store this cycle.
- cpu_we  in  1  CPU store.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU store data.
- cpu_type  in  3  CPU DMType (byte/half/word, signed/unsigned).
- cpu_rdata  out  32  load data to CPU; equals `dm_dout`, combinational.
- cpu_stall  out  1  CPU must freeze the pipeline and hold its request.
- ext_req  in  1  external access request. It must be held, with its fields stable, until `ext_ack`.
- ext_we, ext_addr[31:0], ext_wdata[31:0], ext_type[2:0]  in  external access fields; same meaning as the CPU fields.
- ext_ack  out  1  one-cycle pulse; the external access has completed.
- ext_rdata  out  32  registered load data; valid while `ext_ack` is high and held until the next external grant.
- dm_we  out  1  memory write enable.
- dm_addr  out  32  memory address.
- dm_din  out  32  memory write data.
- dm_type  out  3  memory access type.
- dm_dout  in  32  memory read data.

## Operation

State:
- FSM `st` ∈ {CPU, EXT_ACK}.
- Starvation counter `starve`, width 4 bits, saturating at STARVE_MAX.

Grant logic (combinational, evaluated every cycle):
- `ext_gnt = (st==CPU) & ext_req & (~cpu_req | starve==STARVE_MAX)`.
- `cpu_gnt = cpu_req & ~ext_gnt`.
- `cpu_stall = cpu_req & ext_gnt`.

Memory mux:
- When `ext_gnt` is 1, `dm_addr`/`dm_din`/`dm_type` take the `ext_*` fields.
- Otherwise they take the `cpu_*` fields. The CPU fields are the default even when there is no grant.
- `dm_we = (ext_gnt & ext_we) | (cpu_gnt & cpu_we)`.
- `dm_we` is never 1 without a grant.

State transitions:
- CPU → EXT_ACK when `ext_gnt` is 1. Otherwise the FSM stays in CPU.
- EXT_ACK → CPU unconditionally.
- EXT_ACK never grants the external port, even if `ext_req` is still high. This prevents a double grant while the master is observing the ack.
- In EXT_ACK the CPU is granted whenever `cpu_req` is 1.

Registers updated on each clock edge:
- `ext_ack` is set to `ext_gnt`.
- If `ext_gnt` is 1: `ext_rdata` is set to `dm_dout`. For an external write, `ext_rdata` captures the pre-write contents.
- `starve` update rules:
  - cleared to 0 if `ext_gnt` is 1 or `ext_req` is 0;
  - otherwise, if `cpu_gnt` is 1 and `starve < STARVE_MAX`, incremented by 1;
  - otherwise held.

Reset (`rstn` low, asynchronous, at any time including mid-transaction):
- `st`=CPU, `starve`=0, `ext_ack`=0, `ext_rdata`=0.
- While `rstn` is low, `dm_we`=0 and `cpu_stall`=0 are forced.
- An external access in flight at reset is dropped with no ack. The master must re-request.

## Timing

- CPU access: zero added latency; `cpu_rdata` is valid in the same cycle as `cpu_req` when granted.
- External access:
  - granted in cycle N, the first eligible cycle;
  - write lands at the end of cycle N;
  - `ext_ack` and `ext_rdata` are valid in cycle N+1;
  - earliest next external grant is cycle N+2. If `ext_req` is still high at N+2, it is a new request.
- Worst-case external wait with `cpu_req` held high continuously: STARVE_MAX CPU grants, then the grant. Wait = STARVE_MAX+1 cycles, counted from the first cycle `ext_req` is high through the grant cycle.
- Maximum CPU stall: 1 cycle per external access. Two external grants are always at least 2 cycles apart, so `cpu_stall` is never high for 2 consecutive cycles.
- Simultaneous `cpu_req` and `ext_req` with `starve` < STARVE_MAX: CPU wins and `starve` increments.
- Paths `ext_*`/`cpu_*` → `dm_*` and `cpu_stall` are combinational. No combinational path from `dm_dout` to any control output.

## Test plan

1. Reset:
   - Stimulus: drive `rstn`=0 with `cpu_req`=1 and `cpu_we`=1.
   - Required: `dm_we`=0, `cpu_stall`=0, `ext_ack`=0, `ext_rdata`=0.
   - Release reset; CPU store of 0x12345678 to 0x10 → `dm_we`=1 for that cycle, and a subsequent load returns 0x12345678.
2. Idle-CPU external access:
   - Stimulus: `cpu_req`=0; external write of 0xDEADBEEF to 0x20 at cycle N.
   - Required: `dm_we`=1 in cycle N, `ext_ack`=1 in cycle N+1 only. `ext_req` held through N+1 gives no second grant.
   - External read of 0x20 returns `ext_rdata`=0xDEADBEEF on its ack.
3. Starvation, STARVE_MAX=4:
   - Stimulus: `cpu_req`=1 continuously; `ext_req` raised at cycle 0.
   - Required: CPU granted in cycles 0–3; `ext_gnt` and `cpu_stall`=1 in cycle 4; `ext_ack` in cycle 5; `starve`=0 after cycle 4.
   - CPU granted in cycle 5 even though `ext_req` is still high.
4. Strict priority, STARVE_MAX=0:
   - Stimulus: `cpu_req`=1 with an `ext_req` pulse train.
   - Required: every external grant occurs on the first eligible cycle; external grants alternate with EXT_ACK cycles; `cpu_stall` is never high for 2 consecutive cycles.
5. Counter clear:
   - Stimulus: `ext_req` high for 2 CPU-granted cycles, dropped for 1 cycle, raised again.
   - Required: the counter restarts from 0, and the grant comes 4 CPU grants later, not 2.
6. Reset mid-transaction:
   - Stimulus: assert `rstn`=0 in cycle N+1, while `ext_ack` would be high.
   - Required: `ext_ack` drops to 0 immediately (asynchronously), and after release `st`=CPU.
